// File: rtl/fpnew_simd_lane_gather.sv
// Dispatches one FP operation to NumLanes lane units, collects their results in
// per-lane FIFOs so lanes may finish out of step, then packs and NaN-boxes the output word.
module fpnew_simd_lane_gather #(
    parameter int unsigned  Width         = 64,
    parameter int unsigned  FpWidth       = 32,
    parameter bit           EnableVectors = 1'b1,
    parameter int unsigned  Depth         = 2,
    parameter int unsigned  TagWidth      = 4,
    localparam int unsigned NumLanes      = EnableVectors ? Width / FpWidth : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic                          vectorial_op_i,
    input  logic [NumLanes-1:0]           simd_mask_i,
    input  logic [TagWidth-1:0]           tag_i,
    input  logic                          flush_i,
    output logic [NumLanes-1:0]           lane_in_valid_o,
    input  logic [NumLanes-1:0]           lane_in_ready_i,
    input  logic [NumLanes-1:0]           lane_out_valid_i,
    output logic [NumLanes-1:0]           lane_out_ready_o,
    input  logic [NumLanes*FpWidth-1:0]   lane_result_i,
    input  logic [NumLanes*5-1:0]         lane_status_i,
    input  logic                          lane_ext_bit_i,
    output logic [Width-1:0]              result_o,
    output logic [4:0]                    status_o,
    output logic                          extension_bit_o,
    output logic [TagWidth-1:0]           tag_o,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic                          busy_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [CntW-1:0] cnt_t;

    function automatic ptr_t ptr_inc(input ptr_t p);
        ptr_t n;
        if (p == PtrW'(Depth - 1)) begin
            n = '0;
        end else begin
            n = p + PtrW'(1);
        end
        return n;
    endfunction

    function automatic cnt_t cnt_next(input cnt_t c, input logic push, input logic pop);
        cnt_t n;
        case ({push, pop})
            2'b10:   n = c + CntW'(1);
            2'b01:   n = c - CntW'(1);
            default: n = c;
        endcase
        return n;
    endfunction

    // Op FIFO storage: one entry per accepted operation.
    logic [TagWidth-1:0] op_tag_mem_r  [Depth];
    logic                op_vec_mem_r  [Depth];
    logic [NumLanes-1:0] op_mask_mem_r [Depth];
    ptr_t                op_wptr_r;
    ptr_t                op_rptr_r;
    cnt_t                op_cnt_r;

    // Per-lane result FIFOs; only lane 0 carries the extension bit.
    logic [FpWidth-1:0]  res_mem_r  [NumLanes][Depth];
    logic [4:0]          st_mem_r   [NumLanes][Depth];
    logic                ext_mem_r  [Depth];
    ptr_t                res_wptr_r [NumLanes];
    ptr_t                res_rptr_r [NumLanes];
    cnt_t                res_cnt_r  [NumLanes];

    logic [NumLanes-1:0] act_in_s;
    logic                op_full_s;
    logic                in_ready_s;
    logic                op_push_s;
    logic [NumLanes-1:0] lane_in_valid_s;
    logic [TagWidth-1:0] head_tag_s;
    logic                head_vec_s;
    logic [NumLanes-1:0] head_mask_s;
    logic                head_ext_s;
    logic [NumLanes-1:0] head_act_s;
    logic [NumLanes-1:0] res_nonempty_s;
    logic [NumLanes-1:0] lane_out_ready_s;
    logic [NumLanes-1:0] res_push_s;
    logic [NumLanes-1:0] res_pop_s;
    logic                out_valid_s;
    logic                pop_s;
    logic                busy_s;
    logic [Width-1:0]    result_s;
    logic [4:0]          status_s;

    // Atomic dispatch: every active lane must be ready before the op is accepted.
    always_comb begin
        act_in_s        = '0;
        for (int l = 0; l < NumLanes; l++) begin
            if (l == 32'sd0) begin
                act_in_s[l] = 1'b1;
            end else begin
                act_in_s[l] = vectorial_op_i & EnableVectors;
            end
        end
        op_full_s       = (op_cnt_r == CntW'(Depth));
        in_ready_s      = ~flush_i & ~op_full_s & (&(lane_in_ready_i | ~act_in_s));
        op_push_s       = in_valid_i & in_ready_s;
        lane_in_valid_s = act_in_s & {NumLanes{op_push_s}};
    end

    // Head-of-queue view, collection handshakes and output-side pop decision.
    always_comb begin
        head_tag_s       = op_tag_mem_r[op_rptr_r];
        head_vec_s       = op_vec_mem_r[op_rptr_r];
        head_mask_s      = op_mask_mem_r[op_rptr_r];
        head_ext_s       = ext_mem_r[res_rptr_r[0]];
        head_act_s       = '0;
        res_nonempty_s   = '0;
        lane_out_ready_s = '0;
        for (int l = 0; l < NumLanes; l++) begin
            if (l == 32'sd0) begin
                head_act_s[l] = 1'b1;
            end else begin
                head_act_s[l] = head_vec_s;
            end
            res_nonempty_s[l]   = (res_cnt_r[l] != '0);
            lane_out_ready_s[l] = (res_cnt_r[l] != CntW'(Depth)) & ~flush_i;
        end
        res_push_s  = lane_out_valid_i & lane_out_ready_s;
        out_valid_s = (op_cnt_r != '0) & (&(res_nonempty_s | ~head_act_s));
        pop_s       = out_valid_s & out_ready_i & ~flush_i;
        res_pop_s   = head_act_s & {NumLanes{pop_s}};
        busy_s      = (op_cnt_r != '0) | (|res_nonempty_s);
    end

    // Result packing: inactive slices and the unused top bits are boxed with the ext bit.
    always_comb begin
        result_s = {Width{head_ext_s}};
        status_s = 5'b00000;
        for (int l = 0; l < NumLanes; l++) begin
            if (head_act_s[l]) begin
                result_s[l*FpWidth +: FpWidth] = res_mem_r[l][res_rptr_r[l]];
                status_s = status_s | (st_mem_r[l][res_rptr_r[l]] & {5{head_mask_s[l]}});
            end else begin
                result_s[l*FpWidth +: FpWidth] = {FpWidth{head_ext_s}};
                status_s = status_s;
            end
        end
    end

    // Op FIFO: pointers, occupancy and entry storage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_wptr_r <= '0;
            op_rptr_r <= '0;
            op_cnt_r  <= '0;
            for (int i = 0; i < Depth; i++) begin
                op_tag_mem_r[i]  <= '0;
                op_vec_mem_r[i]  <= 1'b0;
                op_mask_mem_r[i] <= '0;
            end
        end else if (flush_i) begin
            op_wptr_r <= '0;
            op_rptr_r <= '0;
            op_cnt_r  <= '0;
        end else begin
            if (op_push_s) begin
                op_tag_mem_r[op_wptr_r]  <= tag_i;
                op_vec_mem_r[op_wptr_r]  <= vectorial_op_i & EnableVectors;
                op_mask_mem_r[op_wptr_r] <= simd_mask_i;
                op_wptr_r                <= ptr_inc(op_wptr_r);
            end
            if (pop_s) begin
                op_rptr_r <= ptr_inc(op_rptr_r);
            end
            op_cnt_r <= cnt_next(op_cnt_r, op_push_s, pop_s);
        end
    end

    // Per-lane result FIFOs: each lane pushes independently, pops happen together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int l = 0; l < NumLanes; l++) begin
                res_wptr_r[l] <= '0;
                res_rptr_r[l] <= '0;
                res_cnt_r[l]  <= '0;
                for (int i = 0; i < Depth; i++) begin
                    res_mem_r[l][i] <= '0;
                    st_mem_r[l][i]  <= '0;
                end
            end
            for (int i = 0; i < Depth; i++) begin
                ext_mem_r[i] <= 1'b0;
            end
        end else if (flush_i) begin
            for (int l = 0; l < NumLanes; l++) begin
                res_wptr_r[l] <= '0;
                res_rptr_r[l] <= '0;
                res_cnt_r[l]  <= '0;
            end
        end else begin
            for (int l = 0; l < NumLanes; l++) begin
                if (res_push_s[l]) begin
                    res_mem_r[l][res_wptr_r[l]] <= lane_result_i[l*FpWidth +: FpWidth];
                    st_mem_r[l][res_wptr_r[l]]  <= lane_status_i[l*5 +: 5];
                    res_wptr_r[l]               <= ptr_inc(res_wptr_r[l]);
                end
                if (res_pop_s[l]) begin
                    res_rptr_r[l] <= ptr_inc(res_rptr_r[l]);
                end
                res_cnt_r[l] <= cnt_next(res_cnt_r[l], res_push_s[l], res_pop_s[l]);
            end
            if (res_push_s[0]) begin
                ext_mem_r[res_wptr_r[0]] <= lane_ext_bit_i;
            end
        end
    end

    assign in_ready_o       = in_ready_s;
    assign lane_in_valid_o  = lane_in_valid_s;
    assign lane_out_ready_o = lane_out_ready_s;
    assign result_o         = result_s;
    assign status_o         = status_s;
    assign extension_bit_o  = head_ext_s;
    assign tag_o            = head_tag_s;
    assign out_valid_o      = out_valid_s;
    assign busy_o           = busy_s;

endmodule

// File: tb/tb_fpnew_simd_lane_gather.sv
// Bench for fpnew_simd_lane_gather: dispatch table, directed corner sequences,
// and randomized traffic checked against a queue-based model of ops and lane results.
module tb_fpnew_simd_lane_gather;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, vec_op, flush, out_valid, out_ready, busy;
    logic [1:0]  simd_mask, lane_in_valid, lane_in_ready, lane_out_valid, lane_out_ready;
    logic [3:0]  tag, tag_out;
    logic [63:0] lane_result, result;
    logic [9:0]  lane_status;
    logic        lane_ext, ext_out;
    logic [4:0]  status;

    logic        s_in_valid, s_in_ready, s_vec_op, s_out_valid, s_out_ready, s_busy;
    logic [0:0]  s_mask, s_lane_in_valid, s_lane_in_ready, s_lane_out_valid, s_lane_out_ready;
    logic [3:0]  s_tag, s_tag_out;
    logic [31:0] s_lane_result;
    logic [4:0]  s_lane_status, s_status;
    logic        s_lane_ext, s_ext_out;
    logic [63:0] s_result;

    int total = 0;
    int bad   = 0;

    typedef struct { logic iv; logic vec; logic [1:0] lir; logic fl; logic ir; logic [1:0] liv; } vec_t;
    typedef struct { logic [3:0] tag; logic vec; logic [1:0] mask; } op_t;
    typedef struct { logic [31:0] res; logic [4:0] st; logic ext; } res_t;

    vec_t tbl [8];
    op_t  oq[$];
    res_t rq0[$];
    res_t rq1[$];
    int   pend0, pend1;

    always #5 clk = ~clk;

    fpnew_simd_lane_gather dut (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .vectorial_op_i(vec_op), .simd_mask_i(simd_mask), .tag_i(tag), .flush_i(flush),
        .lane_in_valid_o(lane_in_valid), .lane_in_ready_i(lane_in_ready),
        .lane_out_valid_i(lane_out_valid), .lane_out_ready_o(lane_out_ready),
        .lane_result_i(lane_result), .lane_status_i(lane_status), .lane_ext_bit_i(lane_ext),
        .result_o(result), .status_o(status), .extension_bit_o(ext_out), .tag_o(tag_out),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .busy_o(busy)
    );

    fpnew_simd_lane_gather #(.EnableVectors(1'b0)) dut_s (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(s_in_valid), .in_ready_o(s_in_ready),
        .vectorial_op_i(s_vec_op), .simd_mask_i(s_mask), .tag_i(s_tag), .flush_i(1'b0),
        .lane_in_valid_o(s_lane_in_valid), .lane_in_ready_i(s_lane_in_ready),
        .lane_out_valid_i(s_lane_out_valid), .lane_out_ready_o(s_lane_out_ready),
        .lane_result_i(s_lane_result), .lane_status_i(s_lane_status), .lane_ext_bit_i(s_lane_ext),
        .result_o(s_result), .status_o(s_status), .extension_bit_o(s_ext_out), .tag_o(s_tag_out),
        .out_valid_o(s_out_valid), .out_ready_i(s_out_ready), .busy_o(s_busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        e_ir, e_ov;
        logic [1:0]  e_liv, e_lor, hs;
        logic [63:0] e_res;
        logic [4:0]  e_st;
        logic        acc, pop;
        op_t         o;
        res_t        r;

        tbl[0] = '{1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 2'b01};
        tbl[1] = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00};
        tbl[2] = '{1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00};
        tbl[3] = '{1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00};
        tbl[4] = '{1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 2'b11};
        tbl[5] = '{1'b0, 1'b1, 2'b11, 1'b0, 1'b1, 2'b00};
        tbl[6] = '{1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 2'b00};
        tbl[7] = '{1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 2'b01};

        rst_n = 1'b0; in_valid = 1'b0; vec_op = 1'b0; simd_mask = 2'b00; tag = 4'h0; flush = 1'b0;
        lane_in_ready = 2'b11; lane_out_valid = 2'b00; lane_result = 64'h0; lane_status = 10'h0;
        lane_ext = 1'b0; out_ready = 1'b0;
        s_in_valid = 1'b0; s_vec_op = 1'b0; s_mask = 1'b1; s_tag = 4'h0; s_lane_in_ready = 1'b1;
        s_lane_out_valid = 1'b0; s_lane_result = 32'h0; s_lane_status = 5'h0; s_lane_ext = 1'b0;
        s_out_ready = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_lane_out_ready", 64'(lane_out_ready), 64'd3);
        chk("reset_in_ready", 64'(in_ready), 64'd1);

        // Combinational dispatch rule from the empty state; in_valid drops before the edge.
        for (int i = 0; i < 8; i++) begin
            in_valid = tbl[i].iv; vec_op = tbl[i].vec; lane_in_ready = tbl[i].lir; flush = tbl[i].fl;
            #1;
            chk($sformatf("tbl%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].ir));
            chk($sformatf("tbl%0d_lane_in_valid", i), 64'(lane_in_valid), 64'(tbl[i].liv));
            in_valid = 1'b0; flush = 1'b0; lane_in_ready = 2'b11;
        end
        tick();

        // Scalar op, lane 0 answers three cycles later with ext=1.
        tag = 4'h3; vec_op = 1'b0; simd_mask = 2'b01; in_valid = 1'b1;
        #1;
        chk("scalar_lane_in_valid", 64'(lane_in_valid), 64'd1);
        tick();
        in_valid = 1'b0;
        tick(); tick();
        lane_out_valid = 2'b01; lane_result = 64'h0000_0000_3F80_0000; lane_ext = 1'b1; lane_status = 10'h001;
        #1;
        chk("scalar_no_bypass", 64'(out_valid), 64'd0);
        tick();
        lane_out_valid = 2'b00;
        #1;
        chk("scalar_out_valid", 64'(out_valid), 64'd1);
        chk("scalar_result", result, 64'hFFFF_FFFF_3F80_0000);
        chk("scalar_tag", 64'(tag_out), 64'h3);
        chk("scalar_ext", 64'(ext_out), 64'd1);
        chk("scalar_status", 64'(status), 64'h01);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0; lane_ext = 1'b0;
        #1;
        chk("scalar_drained", 64'({out_valid, busy}), 64'd0);

        // Vectorial op with lanes finishing out of step; mask hides lane 1 status.
        tag = 4'h5; vec_op = 1'b1; simd_mask = 2'b01; in_valid = 1'b1;
        #1;
        chk("vec_lane_in_valid", 64'(lane_in_valid), 64'd3);
        tick();
        in_valid = 1'b0;
        lane_result = 64'h4000_0000_3F80_0000; lane_status = {5'b00100, 5'b00001};
        for (int c = 1; c <= 7; c++) begin
            lane_out_valid = (c == 2) ? 2'b10 : ((c == 5) ? 2'b01 : 2'b00);
            #1;
            chk($sformatf("vec_out_valid_c%0d", c), 64'(out_valid), 64'(c >= 6));
            tick();
        end
        lane_out_valid = 2'b00;
        #1;
        chk("vec_result", result, 64'h4000_0000_3F80_0000);
        chk("vec_status_masked", 64'(status), 64'h01);
        chk("vec_tag", 64'(tag_out), 64'h5);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Op FIFO full with no downstream ready: third op waits, head output holds.
        vec_op = 1'b0; simd_mask = 2'b01; lane_status = 10'h0; lane_ext = 1'b0;
        tag = 4'h1; in_valid = 1'b1;
        #1; chk("bp_accept1", 64'(in_ready), 64'd1);
        tick();
        tag = 4'h2;
        #1; chk("bp_accept2", 64'(in_ready), 64'd1);
        tick();
        tag = 4'h3;
        lane_out_valid = 2'b01; lane_result = 64'h0000_0000_1111_1111;
        #1;
        chk("bp_full_in_ready", 64'(in_ready), 64'd0);
        chk("bp_full_lane_in_valid", 64'(lane_in_valid), 64'd0);
        tick();
        lane_result = 64'h0000_0000_2222_2222;
        #1;
        chk("bp_head_result", result, 64'h0000_0000_1111_1111);
        tick();
        lane_out_valid = 2'b00;
        #1;
        chk("bp_res_full_ready", 64'(lane_out_ready), 64'd2);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("bp_hold_result%0d", c), result, 64'h0000_0000_1111_1111);
            chk($sformatf("bp_hold_tag%0d", c), 64'(tag_out), 64'h1);
            chk($sformatf("bp_hold_in_ready%0d", c), 64'(in_ready), 64'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_pop_no_passthru", 64'(in_ready), 64'd0);
        tick();
        out_ready = 1'b0;
        #1;
        chk("bp_tag2_head", 64'(tag_out), 64'h2);
        chk("bp_accept3", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        lane_out_valid = 2'b01; lane_result = 64'h0000_0000_3333_3333;
        tick();
        lane_out_valid = 2'b00; out_ready = 1'b1;
        #1;
        chk("bp_order_tag2", 64'(tag_out), 64'h2);
        chk("bp_order_res2", result, 64'h0000_0000_2222_2222);
        tick();
        chk("bp_order_tag3", 64'(tag_out), 64'h3);
        chk("bp_order_res3", result, 64'h0000_0000_3333_3333);
        tick();
        out_ready = 1'b0;
        #1;
        chk("bp_drained", 64'(busy), 64'd0);

        // Flush with two ops in flight; same-cycle handshakes must be dropped.
        vec_op = 1'b1; simd_mask = 2'b11; tag = 4'h6; in_valid = 1'b1;
        tick();
        tag = 4'h7;
        tick();
        in_valid = 1'b0; lane_out_valid = 2'b01;
        tick();
        lane_out_valid = 2'b00;
        #1;
        chk("flush_pre_busy", 64'(busy), 64'd1);
        flush = 1'b1; in_valid = 1'b1; tag = 4'h8; lane_out_valid = 2'b11; out_ready = 1'b1;
        #1;
        chk("flush_in_ready", 64'(in_ready), 64'd0);
        chk("flush_lane_out_ready", 64'(lane_out_ready), 64'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0; lane_out_valid = 2'b00; out_ready = 1'b0;
        #1;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_busy", 64'(busy), 64'd0);
        tag = 4'h9; simd_mask = 2'b10; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; lane_out_valid = 2'b11;
        lane_result = 64'hAAAA_0000_0000_BBBB; lane_status = {5'b01000, 5'b10000};
        tick();
        lane_out_valid = 2'b00;
        #1;
        chk("post_flush_valid", 64'(out_valid), 64'd1);
        chk("post_flush_result", result, 64'hAAAA_0000_0000_BBBB);
        chk("post_flush_status", 64'(status), 64'h08);
        chk("post_flush_tag", 64'(tag_out), 64'h9);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Vectors disabled: vectorial request dispatches lane 0 only, upper half boxed.
        s_vec_op = 1'b1; s_tag = 4'h4; s_in_valid = 1'b1;
        #1;
        chk("novec_lane_in_valid", 64'(s_lane_in_valid), 64'd1);
        chk("novec_in_ready", 64'(s_in_ready), 64'd1);
        tick();
        s_in_valid = 1'b0; s_lane_out_valid = 1'b1; s_lane_result = 32'h1234_5678; s_lane_ext = 1'b1;
        tick();
        s_lane_out_valid = 1'b0;
        #1;
        chk("novec_out_valid", 64'(s_out_valid), 64'd1);
        chk("novec_result", s_result, 64'hFFFF_FFFF_1234_5678);
        chk("novec_tag", 64'(s_tag_out), 64'h4);
        s_out_ready = 1'b1;
        tick();
        s_out_ready = 1'b0;

        // Randomized traffic against the queue model.
        pend0 = 0; pend1 = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            in_valid         = 1'($urandom_range(0, 1));
            vec_op           = 1'($urandom_range(0, 1));
            simd_mask        = 2'($urandom_range(0, 3));
            tag              = 4'($urandom_range(0, 15));
            lane_in_ready[0] = ($urandom_range(0, 3) != 0);
            lane_in_ready[1] = ($urandom_range(0, 3) != 0);
            out_ready        = ($urandom_range(0, 2) != 0);
            lane_out_valid[0] = (pend0 > 0) && ($urandom_range(0, 2) != 0);
            lane_out_valid[1] = (pend1 > 0) && ($urandom_range(0, 2) != 0);
            lane_result      = {32'($urandom), 32'($urandom)};
            lane_status      = 10'($urandom_range(0, 1023));
            lane_ext         = 1'($urandom_range(0, 1));
            #1;
            e_ir  = (oq.size() < 2) && lane_in_ready[0] && (!vec_op || lane_in_ready[1]);
            e_liv = {vec_op && in_valid && e_ir, in_valid && e_ir};
            e_lor = {rq1.size() < 2, rq0.size() < 2};
            e_ov  = (oq.size() > 0) && (rq0.size() > 0) && (!oq[0].vec || rq1.size() > 0);
            chk("rnd_in_ready", 64'(in_ready), 64'(e_ir));
            chk("rnd_lane_in_valid", 64'(lane_in_valid), 64'(e_liv));
            chk("rnd_lane_out_ready", 64'(lane_out_ready), 64'(e_lor));
            chk("rnd_out_valid", 64'(out_valid), 64'(e_ov));
            chk("rnd_busy", 64'(busy), 64'((oq.size() + rq0.size() + rq1.size()) > 0));
            if (e_ov) begin
                e_st = rq0[0].st & {5{oq[0].mask[0]}};
                if (oq[0].vec) begin
                    e_res = {rq1[0].res, rq0[0].res};
                    e_st  = e_st | (rq1[0].st & {5{oq[0].mask[1]}});
                end else begin
                    e_res = {{32{rq0[0].ext}}, rq0[0].res};
                end
                chk("rnd_result", result, e_res);
                chk("rnd_status", 64'(status), 64'(e_st));
                chk("rnd_tag", 64'(tag_out), 64'(oq[0].tag));
                chk("rnd_ext", 64'(ext_out), 64'(rq0[0].ext));
            end
            acc = in_valid && e_ir;
            hs  = lane_out_valid & e_lor;
            pop = e_ov && out_ready;
            if (pop) begin
                o = oq.pop_front();
                r = rq0.pop_front();
                if (o.vec) r = rq1.pop_front();
            end
            if (acc) begin
                oq.push_back('{tag, vec_op, simd_mask});
                pend0++;
                if (vec_op) pend1++;
            end
            if (hs[0]) begin
                rq0.push_back('{lane_result[31:0], lane_status[4:0], lane_ext});
                pend0--;
            end
            if (hs[1]) begin
                rq1.push_back('{lane_result[63:32], lane_status[9:5], 1'b0});
                pend1--;
            end
            @(posedge clk);
            #1;
        end

        // Reset asserted mid-operation returns immediately to the idle state.
        in_valid = 1'b0; lane_out_valid = 2'b00; out_ready = 1'b0; lane_in_ready = 2'b11;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        vec_op = 1'b0; tag = 4'hA; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; lane_out_valid = 2'b01;
        tick();
        lane_out_valid = 2'b00;
        #1;
        chk("midrst_pre_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_lane_out_ready", 64'(lane_out_ready), 64'd3);
        tick();
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fpnew_simd_lane_gather.md
Name: fpnew_simd_lane_gather

Overview:
- Parametrised successor to the lock-step SIMD format slice.
- Dispatches one scalar or vectorial FP operation across NumLanes lane units and collects their results independently, so lanes may finish out of step (e.g. iterative divsqrt).
- Packs the results into one Width-bit word, NaN-boxes/sign-extends unused bits and collapses status under the SIMD mask.
- Holds up to Depth operations in flight. Sits between the opgroup block and per-lane FP units.

Parameters:
- Width, 64, datapath width in bits.
- FpWidth, 32, lane format width; NumLanes = EnableVectors ? Width/FpWidth : 1 (localparam).
- EnableVectors, 1, when 0 only lane 0 exists and vectorial_op_i is ignored.
- Depth, 2, in-flight operations (>=1); sizes the op FIFO and each lane result FIFO.
- TagWidth, 4, width of tag_i/tag_o.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- in_valid_i  in  1  upstream op valid.
- in_ready_o  out  1  upstream ready.
- vectorial_op_i  in  1  op uses all lanes.
- simd_mask_i  in  NumLanes  per-lane status-enable mask.
- tag_i  in  TagWidth  op tag.
- flush_i  in  1  synchronous kill of all in-flight state.
- lane_in_valid_o  out  NumLanes  per-lane dispatch valid.
- lane_in_ready_i  in  NumLanes  per-lane ready; must not depend combinationally on lane_in_valid_o.
- lane_out_valid_i  in  NumLanes  lane result valid.
- lane_out_ready_o  out  NumLanes  lane result ready.
- lane_result_i  in  NumLanes*FpWidth  lane results, lane l at [l*FpWidth +: FpWidth].
- lane_status_i  in  NumLanes*5  lane status {NV,DZ,OF,UF,NX}.
- lane_ext_bit_i  in  1  lane 0 extension bit.
- result_o  out  Width  packed result.
- status_o  out  5  collapsed status.
- extension_bit_o  out  1  extension bit of the head op.
- tag_o  out  TagWidth  tag of the head op.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  downstream ready.
- busy_o  out  1  any op or result in flight.

Behaviour:
- Active lanes: act(l) = (l==0) | (vectorial_op & EnableVectors).
- Reset: all FIFOs empty, pointers/counters 0. Resulting outputs: out_valid_o=0, busy_o=0, lane_out_ready_o all 1, in_ready_o follows the ready rule below; data outputs are don't-care while out_valid_o=0.
- Dispatch:
  - in_ready_o = !flush_i & !op_full & AND over active l of lane_in_ready_i[l].
  - lane_in_valid_o[l] = in_valid_i & act(l) & in_ready_o. Dispatch is atomic: all active lanes or none.
  - On accept, push {tag, vectorial, mask} into the op FIFO.
  - Full op FIFO blocks even if a pop happens in the same cycle; there is no pass-through.
- Collection:
  - lane_out_ready_o[l] = !res_full[l] & !flush_i.
  - On lane handshake, push {result, status}, plus ext bit for lane 0, into lane l's FIFO. No bypass, so the minimum latency from lane handshake to out_valid_o is 1 cycle.
- Output:
  - out_valid_o = op FIFO non-empty & all active lanes (per head vectorial bit) have non-empty result FIFOs.
  - On out_valid_o & out_ready_i, pop the op FIFO and each active lane's result FIFO in the same edge.
  - result_o:
    - active lane slices carry the lane result;
    - inactive lane slices are filled with the head ext bit;
    - bits [Width-1:NumLanes*FpWidth] are the sign-extension of the head ext bit.
  - status_o = OR over active l of (status[l] & {5{mask[l]}}).
  - tag_o and extension_bit_o come from the head entry.
  - Output data holds stable while out_valid_o=1 and out_ready_i=0.
- Pointers: per FIFO, with count width $clog2(Depth+1). Wrap-around from Depth-1 to 0. Depth=1 must work.
- Simultaneous push and pop on a non-empty, non-full FIFO: count unchanged, both pointers advance.
- flush_i:
  - next edge empties all FIFOs;
  - same-cycle handshakes on either side are discarded;
  - out_valid_o is 0 from the next cycle.
  - Lane units flush themselves on the same flush_i.
- busy_o = op FIFO non-empty | any result FIFO non-empty.
- Reset asserted mid-operation: immediately returns to the reset state; in-flight data is lost.

Test Plan:
- Scalar op, Width=64, FpWidth=32, lane0 ext=1 returns 0x3F800000 after 3 cycles -> one cycle later result_o=0xFFFFFFFF_3F800000, lane_in_valid_o=01.
- Vectorial op, lane1 returns 0x40000000 at cycle 2 and lane0 returns 0x3F800000 at cycle 5 -> out_valid_o first high cycle 6, result_o=0x40000000_3F800000.
- Vectorial op, mask=01, lane0 status NX, lane1 status OF -> status_o=5'b00001.
- Depth=2, out_ready_i=0, issue 3 ops -> third held with in_ready_o=0 until first pop; outputs stable; tags emerge in order.
- Two ops in flight, flush_i for 1 cycle -> next cycle out_valid_o=0 and busy_o=0; a new op after flush completes normally.
- EnableVectors=0, vectorial_op_i=1 -> only lane 0 dispatched; upper 32 bits equal ext bit.
